// File: rtl/fpu_seq_if.sv
// -----------------------------------------------------------------------------
// fpu_seq_if
// Request/response bundle for the sequential floating-point unit.
//   Request  : valid_i, ready_o, op_i[3:0], in1_i[W-1:0], in2_i[W-1:0]
//   Response : valid_o, ready_i, out_o[W-1:0], overflow_o, invalid_o
// Signal suffixes are named from the FPU's point of view. The FPU connects
// through the slave modport; the operand-issue/writeback side uses master.
// -----------------------------------------------------------------------------
interface fpu_seq_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 7
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         valid_i;
    logic         ready_o;
    logic [3:0]   op_i;
    logic [W-1:0] in1_i;
    logic [W-1:0] in2_i;
    logic         valid_o;
    logic         ready_i;
    logic [W-1:0] out_o;
    logic         overflow_o;
    logic         invalid_o;

    modport slave (
        input  valid_i, op_i, in1_i, in2_i, ready_i,
        output ready_o, valid_o, out_o, overflow_o, invalid_o
    );

    modport master (
        output valid_i, op_i, in1_i, in2_i, ready_i,
        input  ready_o, valid_o, out_o, overflow_o, invalid_o
    );
endinterface

// File: rtl/fpu_seq.sv
// -----------------------------------------------------------------------------
// fpu_seq
// Multi-cycle add/sub/mul/div on a parametrised IEEE-style format (bf16 by
// default). One operation in flight; division uses a restoring divider that
// produces one quotient bit per cycle. Denormals flush to zero, rounding is
// nearest-even, overflow saturates to Inf.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - fpu_seq_if.slave (request handshake, operands, result, flags)
// -----------------------------------------------------------------------------
module fpu_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 7
) (
    input  logic     clk,
    input  logic     rst,
    fpu_seq_if.slave bus
);
    localparam int W         = 1 + EXP_W + MAN_W;
    localparam int P         = MAN_W + 1;          // significand incl. hidden bit
    localparam int AW        = 2 * P + 4;          // shared pre-normalisation width
    localparam int EW        = EXP_W + 3;          // signed working exponent
    localparam int LW        = $clog2(AW);
    localparam int DIV_STEPS = P + 2;              // quotient bits incl. guard/round
    localparam int CW        = $clog2(DIV_STEPS + 1);

    localparam logic signed [EW-1:0] BIAS    = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] ONE_E   = EW'(1);
    localparam logic signed [EW-1:0] ZERO_E  = EW'(0);
    localparam logic [W-1:0]   QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic [P+2:0]   ONES_X  = {(P+3){1'b1}};

    typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_EXEC, S_ROUND, S_DONE} state_t;

    typedef struct packed {
        logic             s;
        logic [EXP_W-1:0] e;
        logic [P-1:0]     m;
        logic             z;
        logic             inf;
        logic             nan;
    } unp_t;

    // Field split and classification; exponent 0 (incl. denormals) is zero.
    function automatic unp_t unpack_op(input logic [W-1:0] x);
        unp_t u;
        logic all1;
        u.s   = x[W-1];
        u.e   = x[W-2 -: EXP_W];
        all1  = (u.e == {EXP_W{1'b1}});
        u.z   = (u.e == {EXP_W{1'b0}});
        u.inf = all1 && (x[MAN_W-1:0] == {MAN_W{1'b0}});
        u.nan = all1 && (x[MAN_W-1:0] != {MAN_W{1'b0}});
        u.m   = u.z ? {P{1'b0}} : {1'b1, x[MAN_W-1:0]};
        return u;
    endfunction

    state_t               state_q;
    logic [3:0]           op_q;
    logic [W-1:0]         in1_q, in2_q;
    unp_t                 ua_q, ub_q;
    logic [AW-1:0]        acc_q;
    logic signed [EW-1:0] exp_q;
    logic                 sgn_q;
    logic [P:0]           rem_q;
    logic [P+1:0]         quo_q;
    logic [CW-1:0]        cnt_q;
    logic [W-1:0]         res_q;
    logic                 res_ovf_q, res_inv_q;
    logic                 ready_q, valid_q, ovf_q, inv_q;
    logic [W-1:0]         out_q;

    logic is_add, is_sub, is_mul, is_div, illegal_s;

    // Opcode decode; anything that is not exactly one-hot is illegal.
    always_comb begin
        is_add    = (op_q == 4'b0001);
        is_sub    = (op_q == 4'b0010);
        is_mul    = (op_q == 4'b0100);
        is_div    = (op_q == 4'b1000);
        illegal_s = !(is_add || is_sub || is_mul || is_div);
    end

    logic                 sb_eff, a_big, s_big, s_sml;
    logic [EXP_W-1:0]     e_big, e_sml, d_s;
    logic [P-1:0]         m_big, m_sml;
    logic [P+2:0]         ext_s, shf_s, aln_s;
    logic                 lost_s;
    logic [P+3:0]         sum_s;
    logic [2*P-1:0]       prod_s;
    logic [AW-1:0]        acc_d;
    logic signed [EW-1:0] exp_d;
    logic                 sgn_d;

    // Single-cycle datapath: aligned add/sub with sticky, and the full product.
    always_comb begin
        sb_eff = ub_q.s ^ is_sub;
        a_big  = ({ua_q.e, ua_q.m} >= {ub_q.e, ub_q.m});
        e_big  = a_big ? ua_q.e : ub_q.e;
        e_sml  = a_big ? ub_q.e : ua_q.e;
        m_big  = a_big ? ua_q.m : ub_q.m;
        m_sml  = a_big ? ub_q.m : ua_q.m;
        s_big  = a_big ? ua_q.s : sb_eff;
        s_sml  = a_big ? sb_eff : ua_q.s;
        d_s    = e_big - e_sml;
        // Three extra low bits (guard, round, sticky); anything shifted past
        // them collapses into the sticky position.
        ext_s  = {m_sml, 3'b000};
        lost_s = |(ext_s & ~(ONES_X << d_s));
        shf_s  = ext_s >> d_s;
        aln_s  = {shf_s[P+2:1], shf_s[0] | lost_s};
        if (s_big == s_sml) begin
            sum_s = {1'b0, m_big, 3'b000} + {1'b0, aln_s};
        end else begin
            sum_s = {1'b0, m_big, 3'b000} - {1'b0, aln_s};
        end
        prod_s = {{P{1'b0}}, ua_q.m} * {{P{1'b0}}, ub_q.m};
        // All results are placed so that a normalised leading one sits at AW-2.
        if (is_mul) begin
            acc_d = {prod_s, 4'b0000};
            exp_d = $signed({3'b000, ua_q.e}) + $signed({3'b000, ub_q.e}) - BIAS;
            sgn_d = ua_q.s ^ ub_q.s;
        end else if (is_div) begin
            acc_d = {AW{1'b0}};
            exp_d = $signed({3'b000, ua_q.e}) - $signed({3'b000, ub_q.e}) + BIAS;
            sgn_d = ua_q.s ^ ub_q.s;
        end else begin
            acc_d = {sum_s, {P{1'b0}}};
            exp_d = $signed({3'b000, e_big});
            sgn_d = s_big;
        end
    end

    logic         ge_s;
    logic [P:0]   rdiff_s, rem_d;
    logic [P+1:0] quo_d;

    // One restoring-division step.
    always_comb begin
        ge_s    = (rem_q >= {1'b0, ub_q.m});
        rdiff_s = ge_s ? (rem_q - {1'b0, ub_q.m}) : rem_q;
        rem_d   = rdiff_s << 1;
        quo_d   = {quo_q[P:0], ge_s};
    end

    logic [AW-1:0]        acc_in;
    logic                 stk_in, acc_zero, zsign;
    logic [LW-1:0]        pos_s, lz_s;
    logic [AW-2:0]        nacc;
    logic                 nstk, guard_s, rest_s, rnd_up;
    logic signed [EW-1:0] ne_s, ne_r;
    logic [P-1:0]         mant_s;
    logic [P:0]           mant_r;
    logic [MAN_W-1:0]     frac_s;
    logic [W-1:0]         arith_res;
    logic                 arith_ovf;

    // Normalise, round to nearest-even and range-check the arithmetic result.
    always_comb begin
        acc_in   = is_div ? {1'b0, quo_q, {(AW-P-3){1'b0}}} : acc_q;
        stk_in   = is_div && (rem_q != {(P+1){1'b0}});
        acc_zero = (acc_in == {AW{1'b0}});
        pos_s    = {LW{1'b0}};
        for (int i = 0; i < AW - 1; i++) begin
            if (acc_in[i]) begin
                pos_s = LW'(i);
            end else begin
                pos_s = pos_s;
            end
        end
        lz_s = LW'(AW - 2) - pos_s;
        if (acc_in[AW-1]) begin
            nacc = acc_in[AW-1:1];
            nstk = stk_in | acc_in[0];
            ne_s = exp_q + ONE_E;
        end else begin
            nacc = acc_in[AW-2:0] << lz_s;
            nstk = stk_in;
            ne_s = exp_q - $signed({{(EW-LW){1'b0}}, lz_s});
        end
        mant_s  = nacc[AW-2 -: P];
        guard_s = nacc[AW-2-P];
        rest_s  = (|nacc[AW-3-P:0]) | nstk;
        rnd_up  = guard_s & (rest_s | mant_s[0]);
        mant_r  = {1'b0, mant_s} + {{P{1'b0}}, rnd_up};
        // A rounding carry leaves 1.000..0, so the fraction is zero either way.
        ne_r    = mant_r[P] ? (ne_s + ONE_E) : ne_s;
        frac_s  = mant_r[P] ? mant_r[P-1:1] : mant_r[P-2:0];
        // x-x is +0 in round-to-nearest; only (-0)+(-0) keeps the minus sign.
        zsign   = (is_add || is_sub) ? (ua_q.z & ub_q.z & ua_q.s & sb_eff) : sgn_q;
        if (acc_zero) begin
            arith_res = {zsign, {(W-1){1'b0}}};
            arith_ovf = 1'b0;
        end else if (ne_r >= EXP_MAX) begin
            arith_res = {sgn_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            arith_ovf = 1'b1;
        end else if (ne_r <= ZERO_E) begin
            arith_res = {sgn_q, {(W-1){1'b0}}};
            arith_ovf = 1'b0;
        end else begin
            arith_res = {sgn_q, ne_r[EXP_W-1:0], frac_s};
            arith_ovf = 1'b0;
        end
    end

    logic [W-1:0] res_d;
    logic         ovf_d, inv_d, sgn_x;

    // Special-operand handling overrides the arithmetic result.
    always_comb begin
        sgn_x = ua_q.s ^ ub_q.s;
        ovf_d = 1'b0;
        inv_d = 1'b0;
        res_d = arith_res;
        if (illegal_s || ua_q.nan || ub_q.nan) begin
            res_d = QNAN;
            inv_d = 1'b1;
        end else if (is_add || is_sub) begin
            if (ua_q.inf && ub_q.inf && (ua_q.s != sb_eff)) begin
                res_d = QNAN;
                inv_d = 1'b1;
            end else if (ua_q.inf) begin
                res_d = {ua_q.s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            end else if (ub_q.inf) begin
                res_d = {sb_eff, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            end else begin
                ovf_d = arith_ovf;
            end
        end else if (is_mul) begin
            if ((ua_q.z && ub_q.inf) || (ua_q.inf && ub_q.z)) begin
                res_d = QNAN;
                inv_d = 1'b1;
            end else if (ua_q.inf || ub_q.inf) begin
                res_d = {sgn_x, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            end else begin
                ovf_d = arith_ovf;
            end
        end else begin
            if ((ua_q.z && ub_q.z) || (ua_q.inf && ub_q.inf)) begin
                res_d = QNAN;
                inv_d = 1'b1;
            end else if (ua_q.inf || ub_q.z) begin
                res_d = {sgn_x, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            end else if (ub_q.inf) begin
                res_d = {sgn_x, {(W-1){1'b0}}};
            end else begin
                ovf_d = arith_ovf;
            end
        end
    end

    // Control FSM with all state, datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            op_q      <= 4'b0000;
            in1_q     <= {W{1'b0}};
            in2_q     <= {W{1'b0}};
            ua_q      <= '{default: 1'b0};
            ub_q      <= '{default: 1'b0};
            acc_q     <= {AW{1'b0}};
            exp_q     <= ZERO_E;
            sgn_q     <= 1'b0;
            rem_q     <= {(P+1){1'b0}};
            quo_q     <= {(P+2){1'b0}};
            cnt_q     <= {CW{1'b0}};
            res_q     <= {W{1'b0}};
            res_ovf_q <= 1'b0;
            res_inv_q <= 1'b0;
            ready_q   <= 1'b0;
            valid_q   <= 1'b0;
            out_q     <= {W{1'b0}};
            ovf_q     <= 1'b0;
            inv_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.valid_i && ready_q) begin
                        op_q    <= bus.op_i;
                        in1_q   <= bus.in1_i;
                        in2_q   <= bus.in2_i;
                        ready_q <= 1'b0;
                        state_q <= S_UNPACK;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                S_UNPACK: begin
                    ua_q    <= unpack_op(in1_q);
                    ub_q    <= unpack_op(in2_q);
                    rem_q   <= {1'b0, unpack_op(in1_q).m};
                    quo_q   <= {(P+2){1'b0}};
                    cnt_q   <= {CW{1'b0}};
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    acc_q <= acc_d;
                    exp_q <= exp_d;
                    sgn_q <= sgn_d;
                    if (is_div) begin
                        rem_q <= rem_d;
                        quo_q <= quo_d;
                        cnt_q <= cnt_q + {{(CW-1){1'b0}}, 1'b1};
                        if (cnt_q == CW'(DIV_STEPS - 1)) begin
                            state_q <= S_ROUND;
                        end else begin
                            state_q <= S_EXEC;
                        end
                    end else begin
                        state_q <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    res_q     <= res_d;
                    res_ovf_q <= ovf_d;
                    res_inv_q <= inv_d;
                    state_q   <= S_DONE;
                end
                S_DONE: begin
                    // First DONE cycle loads the output register; after that
                    // outputs hold until the consumer takes the result.
                    if (!valid_q) begin
                        valid_q <= 1'b1;
                        out_q   <= res_q;
                        ovf_q   <= res_ovf_q;
                        inv_q   <= res_inv_q;
                    end else if (bus.ready_i) begin
                        valid_q <= 1'b0;
                        out_q   <= {W{1'b0}};
                        ovf_q   <= 1'b0;
                        inv_q   <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        valid_q <= valid_q;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ready_o    = ready_q;
    assign bus.valid_o    = valid_q;
    assign bus.out_o      = out_q;
    assign bus.overflow_o = ovf_q;
    assign bus.invalid_o  = inv_q;

endmodule

// File: tb/tb_fpu_seq.sv
// -----------------------------------------------------------------------------
// tb_fpu_seq
// Directed-vector bench for fpu_seq (bf16). Stimulus pushes the hand-computed
// expected result into a scoreboard queue; an independent monitor pops and
// compares whenever a result handshake is presented.
// -----------------------------------------------------------------------------
module tb_fpu_seq;
    localparam int EXP_W = 8;
    localparam int MAN_W = 7;
    localparam int W     = 1 + EXP_W + MAN_W;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    fpu_seq_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus();

    fpu_seq #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string        name;
        logic [W-1:0] out;
        logic         ovf;
        logic         inv;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_run  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_run++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: compare every result handshake against the scoreboard head.
    always @(negedge clk) begin
        if (!rst && bus.valid_o && bus.ready_i) begin
            if (sb_q.size() == 0) begin
                n_run++;
                n_fail++;
                $display("FAIL unexpected_result: got 0x%0h, expected no result", bus.out_o);
            end else begin
                mon_e = sb_q.pop_front();
                check({mon_e.name, "_out"}, 32'(bus.out_o), 32'(mon_e.out));
                check({mon_e.name, "_ovf"}, 32'(bus.overflow_o), 32'(mon_e.ovf));
                check({mon_e.name, "_inv"}, 32'(bus.invalid_o), 32'(mon_e.inv));
            end
        end
    end

    // Issue one operation and check the acceptance-to-valid latency.
    task automatic issue(input string name, input logic [3:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eout, input logic eovf,
                         input logic einv, input int elat);
        exp_t e;
        int   n;
        n = 0;
        while (!bus.ready_o && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_ready"}, 32'(bus.ready_o), 32'd1);
        e.name = name;
        e.out  = eout;
        e.ovf  = eovf;
        e.inv  = einv;
        sb_q.push_back(e);
        bus.op_i    = op;
        bus.in1_i   = a;
        bus.in2_i   = b;
        bus.valid_i = 1'b1;
        @(posedge clk); #1;
        bus.valid_i = 1'b0;
        n = 0;
        while (!bus.valid_o && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_latency"}, 32'(n), 32'(elat));
    endtask

    // Wait for the result handshake and check ready returns the next cycle.
    task automatic drain(input string name);
        int n;
        n = 0;
        while (bus.valid_o && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_valid_drop"}, 32'(bus.valid_o), 32'd0);
        check({name, "_ready_back"}, 32'(bus.ready_o), 32'd1);
    endtask

    task automatic run(input string name, input logic [3:0] op,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eout, input logic eovf,
                       input logic einv, input int elat);
        issue(name, op, a, b, eout, eovf, einv, elat);
        drain(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        bus.valid_i = 1'b0;
        bus.op_i    = 4'b0000;
        bus.in1_i   = 16'h0000;
        bus.in2_i   = 16'h0000;
        bus.ready_i = 1'b1;
        rst         = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(bus.ready_o), 32'd0);
        check("rst_valid", 32'(bus.valid_o), 32'd0);
        check("rst_out",   32'(bus.out_o), 32'd0);
        check("rst_ovf",   32'(bus.overflow_o), 32'd0);
        check("rst_inv",   32'(bus.invalid_o), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_ready", 32'(bus.ready_o), 32'd1);

        //   name          op       in1       in2       out       ovf   inv   lat
        run("add_1_2",     4'b0001, 16'h3F80, 16'h4000, 16'h4040, 1'b0, 1'b0, 4);
        run("sub_1_1",     4'b0010, 16'h3F80, 16'h3F80, 16'h0000, 1'b0, 1'b0, 4);
        run("sub_1_2",     4'b0010, 16'h3F80, 16'h4000, 16'hBF80, 1'b0, 1'b0, 4);
        run("div_1_3",     4'b1000, 16'h3F80, 16'h4040, 16'h3EAB, 1'b0, 1'b0, 13);
        run("div_1_0",     4'b1000, 16'h3F80, 16'h0000, 16'h7F80, 1'b0, 1'b0, 13);
        run("mul_ovf",     4'b0100, 16'h7F00, 16'h4000, 16'h7F80, 1'b1, 1'b0, 4);
        run("mul_flush",   4'b0100, 16'h0080, 16'h0080, 16'h0000, 1'b0, 1'b0, 4);
        run("mul_0_inf",   4'b0100, 16'h0000, 16'h7F80, 16'h7FC0, 1'b0, 1'b1, 4);
        run("div_0_0",     4'b1000, 16'h0000, 16'h0000, 16'h7FC0, 1'b0, 1'b1, 13);
        run("op_illegal",  4'b0011, 16'h3F80, 16'h4000, 16'h7FC0, 1'b0, 1'b1, 4);
        run("inf_m_inf",   4'b0001, 16'h7F80, 16'hFF80, 16'h7FC0, 1'b0, 1'b1, 4);
        run("ninf_p_1",    4'b0001, 16'hFF80, 16'h3F80, 16'hFF80, 1'b0, 1'b0, 4);
        run("nz_p_nz",     4'b0001, 16'h8000, 16'h8000, 16'h8000, 1'b0, 1'b0, 4);

        // Back-pressure: result must hold while the consumer stalls.
        bus.ready_i = 1'b0;
        issue("bp_mul", 4'b0100, 16'h4000, 16'h4040, 16'h40C0, 1'b0, 1'b0, 4);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("bp_valid", 32'(bus.valid_o), 32'd1);
            check("bp_out",   32'(bus.out_o), 32'h40C0);
            check("bp_ovf",   32'(bus.overflow_o), 32'd0);
            check("bp_inv",   32'(bus.invalid_o), 32'd0);
            check("bp_ready", 32'(bus.ready_o), 32'd0);
        end
        bus.ready_i = 1'b1;
        drain("bp_mul");

        // Reset five cycles into the divide; the operation must vanish.
        bus.op_i    = 4'b1000;
        bus.in1_i   = 16'h3F80;
        bus.in2_i   = 16'h4040;
        bus.valid_i = 1'b1;
        @(posedge clk); #1;
        bus.valid_i = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("mid_div_busy", 32'(bus.ready_o), 32'd0);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(bus.valid_o), 32'd0);
        check("mid_rst_out",   32'(bus.out_o), 32'd0);
        check("mid_rst_ovf",   32'(bus.overflow_o), 32'd0);
        check("mid_rst_inv",   32'(bus.invalid_o), 32'd0);
        check("mid_rst_ready", 32'(bus.ready_o), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        n = 0;
        while (!bus.ready_o && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check("mid_rst_ready_back", 32'(bus.ready_o), 32'd1);
        run("add_2_2", 4'b0001, 16'h4000, 16'h4000, 16'h4080, 1'b0, 1'b0, 4);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
